// File: rtl/alu_vector_checker.sv
// alu_vector_checker: on-chip BIST engine for the ALU datapath.
// Reads packed {a, b, opSel, expResult, expCarry, expSign, expZero} vectors
// from a synchronous-read ROM, applies the operands to the ALU, waits SETTLE
// cycles, then compares the ALU result and flags with the expected values.
// Optional feature macro: ALU_CHK_STOP_ON_FAIL_EN (end the run on the first mismatch).
module alu_vector_checker #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DEPTH  = 15362,
    parameter int unsigned SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       start,
    input  logic [ADDR_W:0]            numVectors,
    output logic                       vecRd,
    output logic [ADDR_W-1:0]          vecAddr,
    input  logic [3*DATA_W+OP_W+2:0]   vecData,
    output logic [DATA_W-1:0]          aluA,
    output logic [DATA_W-1:0]          aluB,
    output logic [OP_W-1:0]            aluOpSel,
    input  logic [DATA_W-1:0]          aluResult,
    input  logic                       aluCarry,
    input  logic                       aluSign,
    input  logic                       aluZero,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ADDR_W:0]            errCount,
    output logic [ADDR_W-1:0]          firstFailIdx,
    output logic                       firstFailValid
);

    localparam int unsigned      VEC_W       = 3*DATA_W + OP_W + 3;
    localparam int unsigned      CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [ADDR_W:0]  DEPTH_V     = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] lastIdx;
    logic [CNT_W-1:0]  settleCnt;
    logic [DATA_W-1:0] expResult;
    logic              expCarry;
    logic              expSign;
    logic              expZero;

    logic [ADDR_W:0]   nClamp;
    logic              mismatch;
    logic              lastVec;

    // Clamp the requested count, evaluate the comparison and the end-of-run condition
    always_comb begin
        nClamp   = (numVectors > DEPTH_V) ? DEPTH_V : numVectors;
        mismatch = (aluResult != expResult) | (aluCarry != expCarry) |
                   (aluSign != expSign) | (aluZero != expZero);
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        lastVec  = (index == lastIdx) | mismatch;
`else
        lastVec  = (index == lastIdx);
`endif
    end

    assign vecAddr = index;
    assign pass    = done & (errCount == '0);

    // Control FSM with registered status, strobe and ALU operand outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state          <= S_IDLE;
            index          <= '0;
            lastIdx        <= '0;
            settleCnt      <= '0;
            expResult      <= '0;
            expCarry       <= 1'b0;
            expSign        <= 1'b0;
            expZero        <= 1'b0;
            vecRd          <= 1'b0;
            aluA           <= '0;
            aluB           <= '0;
            aluOpSel       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            errCount       <= '0;
            firstFailIdx   <= '0;
            firstFailValid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // done follows DONE entry by one cycle; a start on that same edge wins
                    if (state == S_DONE) begin
                        done <= 1'b1;
                    end
                    if (start) begin
                        errCount       <= '0;
                        firstFailIdx   <= '0;
                        firstFailValid <= 1'b0;
                        done           <= 1'b0;
                        index          <= '0;
                        lastIdx        <= ADDR_W'(nClamp - (ADDR_W+1)'(1));
                        if (nClamp == '0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_FETCH;
                            busy  <= 1'b1;
                            vecRd <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    vecRd <= 1'b0;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    aluA      <= vecData[VEC_W-1 -: DATA_W];
                    aluB      <= vecData[VEC_W-1-DATA_W -: DATA_W];
                    aluOpSel  <= vecData[3+DATA_W +: OP_W];
                    expResult <= vecData[3 +: DATA_W];
                    expCarry  <= vecData[2];
                    expSign   <= vecData[1];
                    expZero   <= vecData[0];
                    settleCnt <= '0;
                    state     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settleCnt == SETTLE_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        settleCnt <= settleCnt + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (errCount != '1) begin
                            errCount <= errCount + (ADDR_W+1)'(1);
                        end
                        if (!firstFailValid) begin
                            firstFailIdx   <= index;
                            firstFailValid <= 1'b1;
                        end
                    end
                    if (lastVec) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                    end else begin
                        index <= index + ADDR_W'(1);
                        state <= S_FETCH;
                        vecRd <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    vecRd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_vector_checker.md
# alu_vector_checker

Synthesizable, parametrised self-checking vector engine for the ALU. It reads packed stimulus and expected-response vectors from a synchronous-read vector ROM and drives them onto the ALU operand and opcode ports. After a programmable settle time it compares the ALU result and flags against the expected values, then reports a mismatch count, the first failing index and a pass/fail verdict. It replaces file-driven checking with on-chip BIST for the datapath.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- OP_W, 4, opcode width
- ADDR_W, 14, vector ROM address width
- DEPTH, 15362, vector ROM depth (≤ 2^ADDR_W)
- SETTLE, 1, cycles held after operands are applied before sampling the ALU (≥ 1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - rstN  in  1  asynchronous active-low reset
- Control:
  - start  in  1  begin run; sampled in IDLE only
  - numVectors  in  ADDR_W+1  vectors to run; values > DEPTH are clamped to DEPTH
- Vector ROM:
  - vecRd  out  1  ROM read strobe
  - vecAddr  out  ADDR_W  ROM address
  - vecData  in  3*DATA_W+OP_W+3  {a, b, opSel, expResult, expCarry, expSign, expZero}, MSB first; valid 1 cycle after vecRd
- ALU side:
  - aluA / aluB  out  DATA_W  operands
  - aluOpSel  out  OP_W  opcode
  - aluResult  in  DATA_W  ALU result
  - aluCarry / aluSign / aluZero  in  1  ALU flags
- Status:
  - busy  out  1  run in progress
  - done  out  1  run finished; level, held until next accepted start
  - pass  out  1  valid while done; 1 iff errCount == 0
  - errCount  out  ADDR_W+1  mismatching vectors; saturates at all-ones
  - firstFailIdx  out  ADDR_W  index of first mismatch
  - firstFailValid  out  1  firstFailIdx meaningful

## Operation
- FSM states: IDLE, FETCH, LOAD, SETTLE, CHECK, DONE.
- IDLE with start=1:
  - Clear errCount, firstFailValid, done and index.
  - If the clamped numVectors = 0, go to DONE with pass=1; otherwise go to FETCH.
- FETCH: vecRd=1, vecAddr=index, for one cycle → LOAD.
- LOAD: capture vecData into registers. aluA, aluB and aluOpSel come from these registers and are stable until the next LOAD → SETTLE.
- SETTLE: counts SETTLE cycles → CHECK.
- CHECK: mismatch = (aluResult≠expResult) | any flag ≠ its expected value.
  - On mismatch: errCount+1, saturating. On the first mismatch, latch firstFailIdx=index and set firstFailValid=1.
  - If index == count−1 → DONE; else index+1 → FETCH.
- DONE: done=1, busy=0. start=1 restarts the run exactly as from IDLE.
- busy=1 in FETCH, LOAD, SETTLE and CHECK. start is ignored while busy.
- Reset values: all outputs 0; aluA, aluB, aluOpSel = 0; state IDLE.
- Reset asserted mid-run aborts immediately. No partial status is retained.

## Timing
- Per-vector cost: 3+SETTLE cycles (4 at default).
- With start sampled at edge T, done rises at edge T+1+N·(3+SETTLE).
- The N=0 run has done at T+1.
- ALU inputs change only on the LOAD edge. The ALU is combinational and sampled at the CHECK edge, so the settle window is SETTLE+1 cycles.
- errCount, firstFailIdx and firstFailValid update on the CHECK edge and are readable one cycle later.
- pass is combinational from done and errCount.

## Configuration
- ALU_CHK_STOP_ON_FAIL_EN:
  - Defined: CHECK with a mismatch goes directly to DONE. errCount ends at 1 and firstFailIdx identifies the failing vector.
  - Undefined: all vectors run regardless of mismatches.

## Test plan
- Golden ADD vectors: N=4, DATA_W=32, SETTLE=1, ALU matching all expected values → done at T+17, errCount=0, pass=1, firstFailValid=0.
- Injected faults: vectors 2 and 5 of N=8 carry a corrupted expZero → errCount=2, firstFailIdx=2, pass=0. With ALU_CHK_STOP_ON_FAIL_EN: done at T+1+3·4=T+13, errCount=1.
- Degenerate counts:
  - numVectors=0 → done at T+1, pass=1, vecRd never asserted.
  - numVectors=20000 → clamped to DEPTH; last vecAddr=15361.
- rstN pulled low during SETTLE of vector 3 → busy=0, errCount=0, aluA=0 the same cycle. A subsequent start runs cleanly from index 0.
- Restart and stability:
  - start held high throughout the run → exactly one run; restart only from DONE.
  - aluA stays stable across all SETTLE=3 cycles; per-vector period = 6.
